// File: rtl/epu_dma_master.sv
// AXI4 read/write copy engine feeding the EPU buffer windows: serialized read-burst/write-burst pairs through a local buffer.
// Optional macro EPU_DMA_PERF_EN adds perf_cycles_o, a saturating count of busy cycles.
module epu_dma_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 20
) (
`ifdef EPU_DMA_PERF_EN
  output logic [31:0]       perf_cycles_o,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_src_i,
  input  logic [ADDR_W-1:0] cfg_dst_i,
  input  logic [CNT_W-1:0]  cfg_words_i,
  input  logic              cfg_start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [LEN_W-1:0]  arlen_o,
  output logic              arvalid_o,
  output logic [ID_W-1:0]   arid_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [LEN_W-1:0]  awlen_o,
  output logic              awvalid_o,
  output logic [ID_W-1:0]   awid_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  localparam int BL_W = $clog2(MAX_BURST) + 1;
  localparam logic [BL_W-1:0] BL_ONE = BL_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [BL_W-1:0]   blen_q, blen_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic              err_q, err_d, done_q;
  logic              buf_we_s;
  logic [DATA_W-1:0] buf_q [MAX_BURST];
  logic              unused_ok;

  // Burst length: limited by remaining words, buffer depth and both 4 KB page ends.
  function automatic logic [BL_W-1:0] calc_blen(input logic [9:0] s_w, input logic [9:0] d_w,
                                                input logic [CNT_W-1:0] r);
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] s4k;
    logic [CNT_W-1:0] d4k;
    s4k = CNT_W'(11'd1024 - {1'b0, s_w});
    d4k = CNT_W'(11'd1024 - {1'b0, d_w});
    n   = (r > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : r;
    n   = (s4k < n) ? s4k : n;
    n   = (d4k < n) ? d4k : n;
    return BL_W'(n);
  endfunction

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    blen_d   = blen_q;
    rcnt_d   = rcnt_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    buf_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          src_d  = {cfg_src_i[ADDR_W-1:2], 2'b00};
          dst_d  = {cfg_dst_i[ADDR_W-1:2], 2'b00};
          rem_d  = cfg_words_i;
          err_d  = 1'b0;
          blen_d = calc_blen(src_d[11:2], dst_d[11:2], rem_d);
          state_d = (cfg_words_i == CNT_W'(0)) ? S_DONE : S_AR;
        end
      end
      S_AR: begin
        rcnt_d = BL_W'(0);
        if (arready_i) state_d = S_R;
      end
      S_R: begin
        if (rvalid_i) begin
          buf_we_s = 1'b1;
          rcnt_d   = rcnt_q + BL_ONE;
          if (rresp_i != 2'b00) err_d = 1'b1;
          // Error bursts are still drained on R but never written out.
          if (rlast_i || (rcnt_q == blen_q - BL_ONE)) state_d = err_d ? S_DONE : S_AW;
        end
      end
      S_AW: begin
        wcnt_d = BL_W'(0);
        if (awready_i) state_d = S_W;
      end
      S_W: begin
        if (wready_i) begin
          wcnt_d = wcnt_q + BL_ONE;
          if (wcnt_q == blen_q - BL_ONE) state_d = S_B;
        end
      end
      S_B: begin
        if (bvalid_i) begin
          src_d = src_q + ADDR_W'({blen_q, 2'b00});
          dst_d = dst_q + ADDR_W'({blen_q, 2'b00});
          rem_d = rem_q - CNT_W'(blen_q);
          if (bresp_i != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (rem_d == CNT_W'(0)) begin
            state_d = S_DONE;
          end else begin
            blen_d  = calc_blen(src_d[11:2], dst_d[11:2], rem_d);
            state_d = S_AR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      done_q  <= (state_q == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we_s) buf_q[rcnt_q[LEN_W-1:0]] <= rdata_i;
  end

`ifdef EPU_DMA_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else if ((state_q == S_IDLE) && cfg_start_i) begin
      perf_q <= 32'd0;
    end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

  // Bits [1:0] of the configured addresses are forced to zero.
  assign unused_ok = ^{cfg_src_i[1:0], cfg_dst_i[1:0]};

  // busy covers the DONE state, so it falls in the same cycle done_o pulses.
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign araddr_o  = src_q;
  assign arlen_o   = LEN_W'(blen_q - BL_ONE);
  assign arvalid_o = (state_q == S_AR);
  assign arid_o    = '0;
  assign arsize_o  = 3'b010;
  assign arburst_o = 2'b01;
  assign rready_o  = (state_q == S_R);
  assign awaddr_o  = dst_q;
  assign awlen_o   = LEN_W'(blen_q - BL_ONE);
  assign awvalid_o = (state_q == S_AW);
  assign awid_o    = '0;
  assign awsize_o  = 3'b010;
  assign awburst_o = 2'b01;
  assign wdata_o   = buf_q[wcnt_q[LEN_W-1:0]];
  assign wstrb_o   = 4'hF;
  assign wlast_o   = (state_q == S_W) && (wcnt_q == blen_q - BL_ONE);
  assign wvalid_o  = (state_q == S_W);
  assign bready_o  = (state_q == S_B);

endmodule

// File: tb/tb_epu_dma_master.sv
// Directed bench for epu_dma_master with a reactive AXI slave model (optional stalls and error injection).
module tb_epu_dma_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_src_i, cfg_dst_i;
  logic [19:0] cfg_words_i;
  logic        cfg_start_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] araddr_o, awaddr_o, rdata_i, wdata_o;
  logic [3:0]  arlen_o, awlen_o, arid_o, awid_o, wstrb_o;
  logic [2:0]  arsize_o, awsize_o;
  logic [1:0]  arburst_o, awburst_o, rresp_i, bresp_i;
  logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;

  always #5 clk = ~clk;

  epu_dma_master dut (
    .clk(clk), .rst(rst),
    .cfg_src_i(cfg_src_i), .cfg_dst_i(cfg_dst_i), .cfg_words_i(cfg_words_i), .cfg_start_i(cfg_start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o), .arid_o(arid_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awvalid_o(awvalid_o), .awid_o(awid_o),
    .awsize_o(awsize_o), .awburst_o(awburst_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Set by the stimulus process only, read by the slave.
  logic        stall_en = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;

  // Written by the slave only, read by the stimulus process.
  logic [31:0] ar_addr_log[$], aw_addr_log[$];
  logic [3:0]  ar_len_log[$], aw_len_log[$];
  logic [31:0] dst_mem [logic [31:0]];
  int r_cnt = 0, done_cnt = 0, stab_err = 0, wlast_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (dst_mem.exists(a)) return dst_mem[a];
    else return 32'hDEAD_BEEF;
  endfunction

  // Slave model: decides inputs at each negedge and books the handshakes of the next posedge.
  initial begin : slave
    logic [31:0] rd_addr_q[$];
    logic [3:0]  rd_len_q[$];
    int          r_beat, w_beat;
    logic [31:0] w_addr, a, prev_wdata;
    logic [3:0]  w_len;
    logic        b_pend, prev_wstall;
    r_beat = 0; w_beat = 0; w_addr = 32'd0; w_len = 4'd0; b_pend = 1'b0;
    prev_wstall = 1'b0; prev_wdata = 32'd0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'd0; rresp_i = 2'b00; rlast_i = 1'b0;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_addr_q.delete(); rd_len_q.delete();
        r_beat = 0; b_pend = 1'b0; prev_wstall = 1'b0;
        arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0; awready_i = 1'b0;
        wready_i = 1'b0; bvalid_i = 1'b0;
        continue;
      end
      if (rd_addr_q.size() > 0) begin
        rvalid_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        a        = rd_addr_q[0] + 32'(r_beat * 4);
        rdata_i  = src_word(a);
        rresp_i  = (a == err_addr) ? 2'b10 : 2'b00;
        rlast_i  = (r_beat == int'(rd_len_q[0]));
        if (rvalid_i && rready_o) begin
          r_cnt++;
          if (rlast_i) begin
            void'(rd_addr_q.pop_front()); void'(rd_len_q.pop_front()); r_beat = 0;
          end else r_beat++;
        end
      end else begin
        rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00; rdata_i = 32'd0;
      end
      if (b_pend) begin
        bvalid_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        bresp_i  = 2'b00;
        if (bvalid_i && bready_o) b_pend = 1'b0;
      end else bvalid_i = 1'b0;
      arready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (arvalid_o && arready_i) begin
        ar_addr_log.push_back(araddr_o); ar_len_log.push_back(arlen_o);
        rd_addr_q.push_back(araddr_o); rd_len_q.push_back(arlen_o);
      end
      awready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (awvalid_o && awready_i) begin
        aw_addr_log.push_back(awaddr_o); aw_len_log.push_back(awlen_o);
        w_addr = awaddr_o; w_len = awlen_o; w_beat = 0;
      end
      if (prev_wstall && (!wvalid_o || wdata_o !== prev_wdata)) stab_err++;
      wready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (wvalid_o) begin
        if (wready_i) begin
          if (wlast_o !== (w_beat == int'(w_len))) wlast_err++;
          dst_mem[w_addr + 32'(w_beat * 4)] = wdata_o;
          if (wlast_o) b_pend = 1'b1;
          w_beat++;
        end
        prev_wstall = !wready_i;
        prev_wdata  = wdata_o;
      end else prev_wstall = 1'b0;
      if (done_o) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Pulses start, reports arvalid one cycle later, then waits (bounded) for done_o.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [19:0] w,
                     output logic ar0, output int cyc);
    cfg_src_i = s; cfg_dst_i = d; cfg_words_i = w; cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    ar0 = arvalid_o;
    cyc = 0;
    while (!done_o && cyc < 3000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_data(input string tag, input logic [31:0] s, input logic [31:0] d, input int w);
    for (int i = 0; i < w; i++) chk(tag, mem_rd(d + 32'(4 * i)), src_word(s + 32'(4 * i)));
  endtask

  initial begin : stim
    logic ar0;
    int   cyc, arb, awb, db, rb, sb, lb;
    rst = 1'b1; cfg_src_i = 32'd0; cfg_dst_i = 32'd0; cfg_words_i = 20'd0; cfg_start_i = 1'b0;
    repeat (3) tick();
    chk("reset_ctl", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, busy_o, done_o, err_o}, 8'h00);
    chk("const_ar", {arid_o, arsize_o, arburst_o}, {4'h0, 3'b010, 2'b01});
    chk("const_aw", {awid_o, awsize_o, awburst_o, wstrb_o}, {4'h0, 3'b010, 2'b01, 4'hF});
    rst = 1'b0;
    tick();

    // 40 words, zero wait: 16,16,8
    arb = ar_addr_log.size(); awb = aw_addr_log.size(); db = done_cnt;
    run(32'h0001_0000, 32'h5000_0000, 20'd40, ar0, cyc);
    chk("t1_ar_latency", ar0, 1'b1);
    chk("t1_done", done_o, 1'b1);
    chk("t1_busy_at_done", busy_o, 1'b0);
    chk("t1_err", err_o, 1'b0);
    tick();
    chk("t1_done_1cyc", done_o, 1'b0);
    chk("t1_done_cnt", done_cnt - db, 1);
    chk("t1_ar_cnt", ar_addr_log.size() - arb, 3);
    chk("t1_ar0", ar_addr_log[arb], 32'h0001_0000);
    chk("t1_ar1", ar_addr_log[arb + 1], 32'h0001_0040);
    chk("t1_ar2", ar_addr_log[arb + 2], 32'h0001_0080);
    chk("t1_arlen", {ar_len_log[arb], ar_len_log[arb + 1], ar_len_log[arb + 2]}, {4'd15, 4'd15, 4'd7});
    chk("t1_aw", {aw_addr_log[awb], aw_addr_log[awb + 1], aw_addr_log[awb + 2]},
        {32'h5000_0000, 32'h5000_0040, 32'h5000_0080});
    chk("t1_awlen", {aw_len_log[awb], aw_len_log[awb + 1], aw_len_log[awb + 2]}, {4'd15, 4'd15, 4'd7});
    check_data("t1_data", 32'h0001_0000, 32'h5000_0000, 40);

    // 4 KB split on the source: 4 then 6
    arb = ar_addr_log.size(); awb = aw_addr_log.size();
    run(32'h0001_0FF0, 32'h7000_0000, 20'd10, ar0, cyc);
    chk("t2_done", done_o, 1'b1);
    tick();
    chk("t2_ar_cnt", ar_addr_log.size() - arb, 2);
    chk("t2_ar", {ar_addr_log[arb], ar_addr_log[arb + 1]}, {32'h0001_0FF0, 32'h0001_1000});
    chk("t2_arlen", {ar_len_log[arb], ar_len_log[arb + 1]}, {4'd3, 4'd5});
    chk("t2_aw", {aw_addr_log[awb], aw_addr_log[awb + 1]}, {32'h7000_0000, 32'h7000_0010});
    chk("t2_awlen", {aw_len_log[awb], aw_len_log[awb + 1]}, {4'd3, 4'd5});
    check_data("t2_data", 32'h0001_0FF0, 32'h7000_0000, 10);

    // Zero words: no traffic, done two cycles after start
    arb = ar_addr_log.size(); db = done_cnt;
    cfg_words_i = 20'd0; cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    chk("t3_c1", {arvalid_o, busy_o, done_o}, 3'b010);
    tick();
    chk("t3_c2", {arvalid_o, busy_o, done_o}, 3'b001);
    tick();
    chk("t3_ar_none", ar_addr_log.size() - arb, 0);
    chk("t3_done_cnt", done_cnt - db, 1);

    // Random stalls, 33 words: 16,16,1
    stall_en = 1'b1;
    arb = ar_addr_log.size(); sb = stab_err; lb = wlast_err;
    run(32'h0002_0100, 32'h6000_0000, 20'd33, ar0, cyc);
    chk("t4_done", done_o, 1'b1);
    tick();
    stall_en = 1'b0;
    chk("t4_arlen", {ar_len_log[arb], ar_len_log[arb + 1], ar_len_log[arb + 2]}, {4'd15, 4'd15, 4'd0});
    chk("t4_w_stable", stab_err - sb, 0);
    chk("t4_wlast", wlast_err - lb, 0);
    check_data("t4_data", 32'h0002_0100, 32'h6000_0000, 33);

    // SLVERR on beat 3 of the first burst
    err_addr = 32'h0003_000C;
    awb = aw_addr_log.size(); rb = r_cnt; db = done_cnt;
    run(32'h0003_0000, 32'h5000_0100, 20'd20, ar0, cyc);
    chk("t5_done", done_o, 1'b1);
    chk("t5_err", err_o, 1'b1);
    tick();
    err_addr = 32'hFFFF_FFF0;
    chk("t5_r_beats", r_cnt - rb, 16);
    chk("t5_no_aw", aw_addr_log.size() - awb, 0);
    chk("t5_done_cnt", done_cnt - db, 1);

    // Reset during W of burst 2, then a fresh 5-word copy
    awb = aw_addr_log.size();
    cfg_src_i = 32'h0004_0000; cfg_dst_i = 32'h6000_1000; cfg_words_i = 20'd40; cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    chk("t6_err_cleared", err_o, 1'b0);
    cyc = 0;
    while (!((aw_addr_log.size() - awb == 2) && wvalid_o) && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("t6_reach_w2", wvalid_o, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_reset_ctl", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, busy_o}, 6'h00);
    rst = 1'b0;
    tick();
    arb = ar_addr_log.size();
    run(32'h0005_0000, 32'h5000_0200, 20'd5, ar0, cyc);
    chk("t6_done", done_o, 1'b1);
    chk("t6_err", err_o, 1'b0);
    tick();
    chk("t6_arlen", ar_len_log[arb], 4'd4);
    check_data("t6_data", 32'h0005_0000, 32'h5000_0200, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
